// File: rtl/mem_wb_stage.sv
// mem_wb_stage: handshaked MEM stage with load/store lane handling feeding the MEM/WB register; rst is active-low async
module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int BE_W = XLEN / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_mem,
  input  logic [XLEN-1:0]           instr_mem,
  input  logic [XLEN-1:0]           alu_mem,
  input  logic [XLEN-1:0]           rs2_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  input  logic                      mem_en,
  input  logic                      mem_wr,
  input  logic                      flush,
  output logic                      stall_mem,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [BE_W-1:0]           dmem_be,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      valid_wb,
  output logic                      misalign_wb,
  output logic [XLEN-1:0]           instr_wb,
  output logic [XLEN-1:0]           alu_wb,
  output logic [XLEN-1:0]           mem_wb,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_wb
);
  localparam int OW = $clog2(BE_W);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DRAIN} state_t;
  state_t state;
  logic killed;
  logic [2:0] f3;
  logic [1:0] sz;
  logic [OW-1:0] off;
  logic mis, act, comp;
  logic [XLEN-1:0] c_addr, c_wdata, q_addr, q_wdata, sh, fmt;
  logic [BE_W-1:0] c_be, q_be;
  logic q_we;
  logic [2:0] q_f3;
  logic [OW-1:0] q_off;
  assign f3 = instr_mem[14:12];
  assign sz = (f3[1:0] == 2'd3 && XLEN == 32) ? 2'd2 : f3[1:0];
  assign off = alu_mem[OW-1:0];
  assign mis = sz == 2'd1 ? off[0] : sz == 2'd2 ? |off[1:0] : sz == 2'd3 ? |off : 1'b0;
  assign act = valid_mem & mem_en & !mis & !flush;
  assign c_addr = {alu_mem[XLEN-1:OW], OW'(0)};
  assign c_be = !mem_wr ? '1 : sz == 2'd0 ? BE_W'(1) << off : sz == 2'd1 ? BE_W'(3) << off :
                sz == 2'd2 ? BE_W'(15) << off : '1;
  assign c_wdata = sz == 2'd0 ? {BE_W{rs2_mem[7:0]}} : sz == 2'd1 ? {(XLEN/16){rs2_mem[15:0]}} :
                   sz == 2'd2 ? {(XLEN/32){rs2_mem[31:0]}} : rs2_mem;
  assign sh = dmem_rdata >> {q_off, 3'b000};
  assign fmt = q_f3 == 3'd0 ? XLEN'($signed(sh[7:0])) :
               q_f3 == 3'd1 ? XLEN'($signed(sh[15:0])) :
               q_f3 == 3'd4 ? XLEN'(sh[7:0]) :
               q_f3 == 3'd5 ? XLEN'(sh[15:0]) :
               (q_f3 == 3'd6 && XLEN == 64) ? XLEN'(sh[31:0]) :
               (q_f3 == 3'd3 && XLEN == 64) ? sh : XLEN'($signed(sh[31:0]));
  assign comp = state == IDLE ? (!act | (dmem_gnt & mem_wr)) : state == REQ ? (dmem_gnt & q_we) : dmem_rvalid;
  assign stall_mem = rst & !comp;
  assign dmem_req = rst & (state == IDLE ? act : state == REQ);
  assign dmem_we = state == IDLE ? mem_wr : q_we;
  assign dmem_addr = state == IDLE ? c_addr : q_addr;
  assign dmem_wdata = state == IDLE ? c_wdata : q_wdata;
  assign dmem_be = state == IDLE ? c_be : q_be;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      killed <= 1'b0;
      q_addr <= '0;
      q_wdata <= '0;
      q_be <= '0;
      q_we <= 1'b0;
      q_f3 <= '0;
      q_off <= '0;
      valid_wb <= 1'b0;
      misalign_wb <= 1'b0;
      instr_wb <= '0;
      alu_wb <= '0;
      mem_wb <= '0;
      rd_addr_wb <= '0;
    end else begin
      if (state == IDLE) begin
        q_addr <= c_addr;
        q_wdata <= c_wdata;
        q_be <= c_be;
        q_we <= mem_wr;
        q_f3 <= f3;
        q_off <= off;
      end
      case (state)
        IDLE: if (act) state <= dmem_gnt ? (mem_wr ? IDLE : RSP) : REQ;
        REQ: if (dmem_gnt) begin
          state <= q_we ? IDLE : (killed | flush) ? DRAIN : RSP;
          killed <= !q_we & (killed | flush);
        end else killed <= killed | flush;
        RSP: if (dmem_rvalid) state <= IDLE;
          else if (flush) begin
            state <= DRAIN;
            killed <= 1'b1;
          end
        DRAIN: if (dmem_rvalid) begin
          state <= IDLE;
          killed <= 1'b0;
        end
      endcase
      valid_wb <= comp & valid_mem & !flush & !killed;
      if (comp) begin
        instr_wb <= instr_mem;
        alu_wb <= alu_mem;
        rd_addr_wb <= rd_addr_mem;
        mem_wb <= state == RSP ? fmt : '0;
        misalign_wb <= (state == IDLE) & valid_mem & mem_en & mis & !flush;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized transaction-level check of mem_wb_stage against a byte-lane reference model
module tb_mem_wb_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic valid_mem, mem_en, mem_wr, flush, stall_mem, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] instr_mem, alu_mem, rs2_mem, dmem_addr, dmem_wdata, dmem_rdata, instr_wb, alu_wb, mem_wb;
  logic [4:0] rd_addr_mem, rd_addr_wb;
  logic [3:0] dmem_be;
  logic valid_wb, misalign_wb;
  int checks = 0, errors = 0;
  logic chk_en = 1'b0;
  logic exp_req, exp_stall, exp_done, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0] exp_be;
  logic e_valid, e_mis;
  logic [31:0] e_instr, e_alu, e_mem;
  logic [4:0] e_rd;
  logic m_valid, m_mis;
  logic [31:0] m_instr, m_alu, m_mem;
  logic [4:0] m_rd;
  logic seen_req, seen_stall;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0] seen_be;
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .instr_mem(instr_mem), .alu_mem(alu_mem),
    .rs2_mem(rs2_mem), .rd_addr_mem(rd_addr_mem), .mem_en(mem_en), .mem_wr(mem_wr), .flush(flush),
    .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .valid_wb(valid_wb), .misalign_wb(misalign_wb), .instr_wb(instr_wb),
    .alu_wb(alu_wb), .mem_wb(mem_wb), .rd_addr_wb(rd_addr_wb)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  function automatic int size(input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction
  function automatic logic [31:0] fmt(input logic [31:0] d, input int off, input logic [2:0] f3);
    int n;
    longint v;
    n = size(f3);
    v = 0;
    for (int k = 0; k < n; k++) v += longint'((d >> (8 * (off + k))) & 32'hFF) << (8 * k);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction
  task automatic run_instr(input logic v, input logic [2:0] f3, input logic me, input logic wr,
                           input logic [31:0] a, input logic [31:0] d2, input logic [4:0] rd,
                           input int g, input int r, input int ft, input logic [31:0] rdat);
    int n, done_t, ft2, off;
    logic is_load, mis, acc, flushed;
    logic [31:0] ins;
    ft2 = ft;
    n = size(f3);
    off = int'(a[1:0]);
    is_load = me & !wr;
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
    acc = v & me & !mis & (ft2 != 0);
    done_t = !acc ? 0 : wr ? g : g + r;
    if (ft2 > 0 && ft2 >= done_t) ft2 = -1;
    flushed = ft2 >= 0;
    ins = $urandom;
    ins[14:12] = f3;
    e_valid = v & !flushed;
    e_mis = v & me & mis & !flushed;
    e_instr = ins;
    e_alu = a;
    e_rd = rd;
    e_mem = (is_load && acc && !flushed) ? fmt(rdat, off, f3) : 32'h0;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_we = wr;
    for (int i = 0; i < 4; i++) begin
      exp_be[i] = is_load ? 1'b1 : (i >= off && i < off + n);
      exp_wdata[8*i +: 8] = d2[8*(i % n) +: 8];
    end
    for (int t = 0; t <= done_t; t++) begin
      valid_mem = v;
      instr_mem = ins;
      alu_mem = a;
      rs2_mem = d2;
      rd_addr_mem = rd;
      mem_en = me;
      mem_wr = wr;
      flush = (t == ft2);
      dmem_gnt = acc && (t == g);
      if (is_load && acc && t == g + r) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = rdat;
      end else begin
        dmem_rvalid = (t <= g) && ($urandom % 4 == 0);
        dmem_rdata = $urandom;
      end
      exp_req = acc && (t <= g);
      exp_stall = t < done_t;
      exp_done = t == done_t;
      @(negedge clk);
      if (t == 0) begin
        seen_req = dmem_req;
        seen_stall = stall_mem;
        seen_addr = dmem_addr;
        seen_be = dmem_be;
        seen_wdata = dmem_wdata;
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      {m_valid, m_mis, m_instr, m_alu, m_mem, m_rd} = '0;
      check("rst_valid_wb", valid_wb, 0);
      check("rst_misalign_wb", misalign_wb, 0);
      check("rst_instr_wb", instr_wb, 0);
      check("rst_alu_wb", alu_wb, 0);
      check("rst_mem_wb", mem_wb, 0);
      check("rst_rd_wb", rd_addr_wb, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_stall", stall_mem, 0);
    end else if (chk_en) begin
      check("valid_wb", valid_wb, m_valid);
      check("misalign_wb", misalign_wb, m_mis);
      check("instr_wb", instr_wb, m_instr);
      check("alu_wb", alu_wb, m_alu);
      check("mem_wb", mem_wb, m_mem);
      check("rd_addr_wb", rd_addr_wb, m_rd);
      check("stall_mem", stall_mem, exp_stall);
      check("dmem_req", dmem_req, exp_req);
      if (exp_req) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_be", dmem_be, exp_be);
        check("dmem_wdata", dmem_wdata, exp_wdata);
        check("dmem_we", dmem_we, exp_we);
      end
      if (exp_done) {m_valid, m_mis, m_instr, m_alu, m_mem, m_rd} = {e_valid, e_mis, e_instr, e_alu, e_mem, e_rd};
      else m_valid = 1'b0;
    end
  end
  initial begin
    logic v, me, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int ft;
    {valid_mem, mem_en, mem_wr, flush, dmem_gnt, dmem_rvalid} = '0;
    {instr_mem, alu_mem, rs2_mem, dmem_rdata, rd_addr_mem} = '0;
    {exp_req, exp_stall, exp_done} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    run_instr(1, 3'd0, 0, 0, 32'h0000_1234, 32'h0, 5'd1, 0, 1, -1, 32'h0);
    check("alu_op_alu_wb", alu_wb, 32'h1234);
    check("alu_op_valid_wb", valid_wb, 1);
    check("alu_op_req", seen_req, 0);
    check("alu_op_stall", seen_stall, 0);
    run_instr(1, 3'd0, 1, 0, 32'h0000_0103, 32'h0, 5'd2, 0, 2, -1, 32'h80FF_0000);
    check("lb_mem_wb", mem_wb, 32'hFFFF_FF80);
    check("lb_be", seen_be, 4'hF);
    check("lb_stall_c0", seen_stall, 1);
    run_instr(1, 3'd5, 1, 0, 32'h0000_0102, 32'h0, 5'd3, 1, 1, -1, 32'hBEEF_0000);
    check("lhu_mem_wb", mem_wb, 32'h0000_BEEF);
    run_instr(1, 3'd1, 1, 0, 32'h0000_0102, 32'h0, 5'd3, 0, 1, -1, 32'hBEEF_0000);
    check("lh_mem_wb", mem_wb, 32'hFFFF_BEEF);
    run_instr(1, 3'd0, 1, 1, 32'h0000_0101, 32'h0000_00AB, 5'd0, 3, 1, -1, 32'h0);
    check("sb_addr", seen_addr, 32'h100);
    check("sb_be", seen_be, 4'b0010);
    check("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    check("sb_mem_wb", mem_wb, 32'h0);
    run_instr(1, 3'd2, 1, 0, 32'h0000_0102, 32'h0, 5'd4, 0, 1, -1, 32'h1111_1111);
    check("mis_req", seen_req, 0);
    check("mis_valid_wb", valid_wb, 1);
    check("mis_misalign_wb", misalign_wb, 1);
    check("mis_mem_wb", mem_wb, 32'h0);
    run_instr(1, 3'd2, 1, 0, 32'h0000_0200, 32'h0, 5'd5, 0, 3, 1, 32'hCAFE_0000);
    check("flush_rsp_valid_wb", valid_wb, 0);
    run_instr(1, 3'd0, 0, 0, 32'h0000_0055, 32'h0, 5'd6, 0, 1, -1, 32'h0);
    check("after_flush_valid_wb", valid_wb, 1);
    check("after_flush_alu_wb", alu_wb, 32'h55);
    chk_en = 1'b0;
    valid_mem = 1'b1;
    instr_mem = 32'h0000_2003;
    alu_mem = 32'h200;
    mem_en = 1'b1;
    mem_wr = 1'b0;
    flush = 1'b0;
    dmem_gnt = 1'b1;
    dmem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    #1;
    check("rsp_stall", stall_mem, 1);
    rst = 1'b0;
    #1;
    check("async_rst_stall", stall_mem, 0);
    check("async_rst_req", dmem_req, 0);
    check("async_rst_alu_wb", alu_wb, 0);
    check("async_rst_instr_wb", instr_wb, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    run_instr(1, 3'd2, 1, 0, 32'h0000_0200, 32'h0, 5'd7, 0, 1, -1, 32'h1234_5678);
    check("post_rst_lw_mem_wb", mem_wb, 32'h1234_5678);
    check("post_rst_lw_valid", valid_wb, 1);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 8) != 0;
      me = ($urandom % 3) != 0;
      wr = me && ($urandom % 2 == 1);
      f3 = wr ? 3'($urandom % 3) : 3'($urandom % 7);
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = 2'd0;
      ft = ($urandom % 5 == 0) ? int'($urandom % 6) : -1;
      run_instr(v, f3, me, wr, a, $urandom, 5'($urandom), int'($urandom % 4), 1 + int'($urandom % 3), ft, $urandom);
    end
    run_instr(0, 3'd0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 1, -1, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
